// File: rtl/imem_boot_loader_pkg.sv
// rtl/imem_boot_loader_pkg.sv - shared constants for the instruction-memory boot loader
//
// Word width, image length width and the loader FSM state encoding.
// CSUM is only reachable when IMEM_BOOT_LOADER_CHECKSUM_EN is defined.

package imem_boot_loader_pkg;

   localparam int WIDTH = 32;
   localparam int LEN_W = 16;

   localparam logic [2:0] HDR_HI = 3'd0;
   localparam logic [2:0] HDR_LO = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] WRITE  = 3'd3;
   localparam logic [2:0] CSUM   = 3'd4;
   localparam logic [2:0] DONE   = 3'd5;
   localparam logic [2:0] ERR    = 3'd6;

endpackage

// File: rtl/imem_boot_loader_word_asm.sv
// rtl/imem_boot_loader_word_asm.sv - packs host bytes into big-endian words
//
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   shift_en    a data byte is accepted this cycle
//   byte_data   the byte being accepted
//   word        assembled word including the byte presented this cycle
//   word_full   pulse: the byte accepted this cycle completes a word

module loader_word_asm #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             shift_en,
   input  logic [7:0]       byte_data,
   output logic [WIDTH-1:0] word,
   output logic             word_full
);

   logic [WIDTH-9:0] shreg;
   logic [1:0]       idx;

   // The word is exposed with the current byte already shifted in, so the
   // FSM can register it on the same edge that accepts the last byte.
   assign word      = {shreg, byte_data};
   assign word_full = shift_en && (idx == 2'd3);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg <= '0;
         idx   <= 2'd0;
      end else if (shift_en) begin
         shreg <= word[WIDTH-9:0];
         idx   <= idx + 2'd1;
      end
   end

endmodule

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - loads a host byte image into instruction memory, then releases the core
//
// Optional feature macro: IMEM_BOOT_LOADER_CHECKSUM_EN (trailing XOR checksum byte).
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   byte_valid/byte_data   host byte stream
//   byte_ready             loader accepts byte_data this cycle
//   imem_we/addr/wdata     instruction memory write port (one-cycle strobe)
//   cpu_rst                core reset, held high until the image is loaded
//   load_done, load_err    sticky completion / rejection flags
//   word_count             words written so far

module imem_boot_loader #(
   parameter int WIDTH     = 32,
   parameter int ADDR_W    = 8,
   parameter int MAX_WORDS = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [WIDTH-1:0]  imem_wdata,
   output logic              cpu_rst,
   output logic              load_done,
   output logic              load_err,
   output logic [15:0]       word_count
);

   import imem_boot_loader_pkg::*;

   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);

   logic [2:0]       state;
   logic [LEN_W-1:0] len;
   logic [LEN_W-1:0] count_inc;
   logic [LEN_W-1:0] len_rx;
   logic             accept;
   logic [WIDTH-1:0] word;
   logic             word_full;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
   logic [7:0]       csum;
`endif

   always_comb begin
      byte_ready = 1'b0;
      case (state)
         HDR_HI, HDR_LO, DATA: byte_ready = 1'b1;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
         CSUM:                 byte_ready = 1'b1;
`endif
         default:              byte_ready = 1'b0;
      endcase
   end

   assign accept    = byte_valid && byte_ready;
   assign count_inc = word_count + 16'd1;
   assign len_rx    = {len[15:8], byte_data};

   // Terminal flags come straight from the state so they are sticky and
   // cpu_rst drops on the very edge that enters DONE.
   assign cpu_rst   = (state != DONE);
   assign load_done = (state == DONE);
   assign load_err  = (state == ERR);

   loader_word_asm #(.WIDTH(WIDTH)) u_word_asm (
      .clk       (clk),
      .rst       (rst),
      .shift_en  (accept && (state == DATA)),
      .byte_data (byte_data),
      .word      (word),
      .word_full (word_full)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= HDR_HI;
         len        <= '0;
         word_count <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
         csum       <= 8'd0;
`endif
      end else begin
         imem_we <= 1'b0;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
         if (accept && (state != CSUM))
            csum <= csum ^ byte_data;
`endif
         case (state)
            HDR_HI: begin
               if (accept) begin
                  len[15:8] <= byte_data;
                  state     <= HDR_LO;
               end
            end
            HDR_LO: begin
               if (accept) begin
                  len[7:0] <= byte_data;
                  if ((len_rx == '0) || (len_rx > MAX_LEN))
                     state <= ERR;
                  else
                     state <= DATA;
               end
            end
            DATA: begin
               // Write strobe, address and data are registered here so they
               // are valid for exactly the WRITE cycle and hold afterwards.
               if (word_full) begin
                  state      <= WRITE;
                  imem_we    <= 1'b1;
                  imem_addr  <= word_count[ADDR_W-1:0];
                  imem_wdata <= word;
               end
            end
            WRITE: begin
               word_count <= count_inc;
               if (count_inc == len)
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
                  state <= CSUM;
`else
                  state <= DONE;
`endif
               else
                  state <= DATA;
            end
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
            CSUM: begin
               if (accept)
                  state <= (byte_data == csum) ? DONE : ERR;
            end
`endif
            DONE, ERR: state <= state;
            default:   state <= ERR;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - self-checking bench for imem_boot_loader

module tb_imem_boot_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = 8'h00;
   logic        byte_ready;
   logic        imem_we;
   logic [7:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_rst;
   logic        load_done;
   logic        load_err;
   logic [15:0] word_count;

   always #5 clk = ~clk;

   imem_boot_loader #(.WIDTH(32), .ADDR_W(8), .MAX_WORDS(256)) dut (
      .clk        (clk),
      .rst        (rst),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_rst    (cpu_rst),
      .load_done  (load_done),
      .load_err   (load_err),
      .word_count (word_count)
   );

   typedef struct {
      logic        r;
      logic        v;
      logic [7:0]  d;
      logic [60:0] exp;
   } vec_t;

   vec_t        vecs[$];
   int          checks = 0;
   int          failures = 0;
   logic [7:0]  wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   int          rdy_viol = 0;
   bit          mon_en = 1'b0;

`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
   localparam logic [7:0] GOOD_CSUM = 8'hAE;
`endif

   function automatic logic [60:0] pk(input logic rdy, input logic we, input logic [7:0] a,
                                      input logic [31:0] w, input logic cr, input logic dn,
                                      input logic er, input logic [15:0] c);
      return {rdy, we, a, w, cr, dn, er, c};
   endfunction

   task automatic add(input logic r, input logic v, input logic [7:0] d, input logic rdy,
                      input logic we, input logic [7:0] a, input logic [31:0] w,
                      input logic cr, input logic dn, input logic er, input logic [15:0] c);
      vec_t e;
      e.r = r; e.v = v; e.d = d;
      e.exp = pk(rdy, we, a, w, cr, dn, er, c);
      vecs.push_back(e);
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (imem_we) begin
         wr_addr_q.push_back(imem_addr);
         wr_data_q.push_back(imem_wdata);
      end
      if (mon_en && !load_done && !load_err && (byte_ready == imem_we))
         rdy_viol++;
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      int budget;
      repeat (gap) begin
         @(negedge clk);
         byte_valid = 1'b0;
      end
      @(negedge clk);
      byte_valid = 1'b1;
      byte_data  = b;
      #1;
      budget = 20;
      while (!byte_ready && budget > 0) begin
         @(negedge clk);
         #1;
         budget--;
      end
      if (!byte_ready) begin
         checks++;
         failures++;
         $display("FAIL send_byte_timeout actual=ready_low required=ready_high byte=%0h", b);
      end
      @(posedge clk);
   endtask

   task automatic idle();
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      byte_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      wr_addr_q.delete();
      wr_data_q.delete();
   endtask

   task automatic send_image(input int gap);
      logic [7:0] img[10];
      img = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
      for (int i = 0; i < 10; i++) send_byte(img[i], gap);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!(load_done || load_err) && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("wait_terminal", 64'(load_done || load_err), 64'd1);
   endtask

   task automatic check_two_writes(input string tag);
      check({tag, "_nwrites"}, 64'(wr_addr_q.size()), 64'd2);
      if (wr_addr_q.size() == 2) begin
         check({tag, "_addr0"}, 64'(wr_addr_q[0]), 64'h00);
         check({tag, "_data0"}, 64'(wr_data_q[0]), 64'h20080005);
         check({tag, "_addr1"}, 64'(wr_addr_q[1]), 64'h01);
         check({tag, "_data1"}, 64'(wr_data_q[1]), 64'h8C090004);
      end
      check({tag, "_done"}, 64'(load_done), 64'd1);
      check({tag, "_cpu_rst"}, 64'(cpu_rst), 64'd0);
      check({tag, "_count"}, 64'(word_count), 64'd2);
   endtask

   initial begin
      // Good image, byte_valid held high
      add(1, 0, 8'h00, 1, 0, 8'h00, 32'h0,        1, 0, 0, 16'd0);
      add(0, 1, 8'h00, 1, 0, 8'h00, 32'h0,        1, 0, 0, 16'd0);
      add(0, 1, 8'h02, 1, 0, 8'h00, 32'h0,        1, 0, 0, 16'd0);
      add(0, 1, 8'h20, 1, 0, 8'h00, 32'h0,        1, 0, 0, 16'd0);
      add(0, 1, 8'h08, 1, 0, 8'h00, 32'h0,        1, 0, 0, 16'd0);
      add(0, 1, 8'h00, 1, 0, 8'h00, 32'h0,        1, 0, 0, 16'd0);
      add(0, 1, 8'h05, 1, 0, 8'h00, 32'h0,        1, 0, 0, 16'd0);
      add(0, 1, 8'h8C, 0, 1, 8'h00, 32'h20080005, 1, 0, 0, 16'd0);
      add(0, 1, 8'h8C, 1, 0, 8'h00, 32'h20080005, 1, 0, 0, 16'd1);
      add(0, 1, 8'h09, 1, 0, 8'h00, 32'h20080005, 1, 0, 0, 16'd1);
      add(0, 1, 8'h00, 1, 0, 8'h00, 32'h20080005, 1, 0, 0, 16'd1);
      add(0, 1, 8'h04, 1, 0, 8'h00, 32'h20080005, 1, 0, 0, 16'd1);
      add(0, 0, 8'h00, 0, 1, 8'h01, 32'h8C090004, 1, 0, 0, 16'd1);
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
      add(0, 1, GOOD_CSUM, 1, 0, 8'h01, 32'h8C090004, 1, 0, 0, 16'd2);
`else
      add(0, 1, 8'h55, 0, 0, 8'h01, 32'h8C090004, 0, 1, 0, 16'd2);
`endif
      add(0, 1, 8'h55, 0, 0, 8'h01, 32'h8C090004, 0, 1, 0, 16'd2);
      add(0, 1, 8'h55, 0, 0, 8'h01, 32'h8C090004, 0, 1, 0, 16'd2);
      // Zero length
      add(1, 0, 8'h00, 1, 0, 8'h00, 32'h0, 1, 0, 0, 16'd0);
      add(0, 1, 8'h00, 1, 0, 8'h00, 32'h0, 1, 0, 0, 16'd0);
      add(0, 1, 8'h00, 1, 0, 8'h00, 32'h0, 1, 0, 0, 16'd0);
      add(0, 1, 8'h20, 0, 0, 8'h00, 32'h0, 1, 0, 1, 16'd0);
      add(0, 1, 8'h20, 0, 0, 8'h00, 32'h0, 1, 0, 1, 16'd0);
      add(0, 0, 8'h00, 0, 0, 8'h00, 32'h0, 1, 0, 1, 16'd0);
      // Oversize length 0x0101
      add(1, 0, 8'h00, 1, 0, 8'h00, 32'h0, 1, 0, 0, 16'd0);
      add(0, 1, 8'h01, 1, 0, 8'h00, 32'h0, 1, 0, 0, 16'd0);
      add(0, 1, 8'h01, 1, 0, 8'h00, 32'h0, 1, 0, 0, 16'd0);
      add(0, 1, 8'h20, 0, 0, 8'h00, 32'h0, 1, 0, 1, 16'd0);
      add(0, 1, 8'h08, 0, 0, 8'h00, 32'h0, 1, 0, 1, 16'd0);
      add(0, 1, 8'h00, 0, 0, 8'h00, 32'h0, 1, 0, 1, 16'd0);

      foreach (vecs[i]) begin
         @(negedge clk);
         rst        = vecs[i].r;
         byte_valid = vecs[i].v;
         byte_data  = vecs[i].d;
         #1;
         check($sformatf("row%0d", i),
               64'(pk(byte_ready, imem_we, imem_addr, imem_wdata, cpu_rst, load_done, load_err, word_count)),
               64'(vecs[i].exp));
      end

      // Host gaps: three idle cycles before every byte
      do_reset();
      rdy_viol = 0;
      mon_en = 1'b1;
      send_image(3);
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
      send_byte(GOOD_CSUM, 3);
`endif
      idle();
      wait_done();
      mon_en = 1'b0;
      check_two_writes("gaps");
      check("gaps_ready_vs_write", 64'(rdy_viol), 64'd0);

      // Reset in the middle of a load, asserted during the first WRITE cycle
      do_reset();
      send_byte(8'h00, 0); send_byte(8'h02, 0); send_byte(8'h20, 0);
      send_byte(8'h08, 0); send_byte(8'h00, 0); send_byte(8'h05, 0);
      #1;
      check("midrst_we_before", 64'(imem_we), 64'd1);
      rst = 1'b1;
      #1;
      check("midrst_async_reset",
            64'(pk(byte_ready, imem_we, imem_addr, imem_wdata, cpu_rst, load_done, load_err, word_count)),
            64'(pk(1, 0, 8'h00, 32'h0, 1, 0, 0, 16'd0)));
      @(negedge clk);
      byte_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      wr_addr_q.delete();
      wr_data_q.delete();
      send_image(0);
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
      send_byte(GOOD_CSUM, 0);
`endif
      idle();
      wait_done();
      check_two_writes("reload");

      // Largest image: 256 words, word i is four copies of byte i
      do_reset();
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      for (int i = 0; i < 256; i++)
         for (int j = 0; j < 4; j++) send_byte(8'(i), 0);
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
      send_byte(8'h01, 0);
`endif
      idle();
      wait_done();
      check("max_nwrites", 64'(wr_addr_q.size()), 64'd256);
      begin
         int bad;
         bad = 0;
         for (int i = 0; i < wr_addr_q.size() && i < 256; i++)
            if (wr_addr_q[i] !== 8'(i) || wr_data_q[i] !== {4{8'(i)}}) bad++;
         check("max_write_contents", 64'(bad), 64'd0);
      end
      if (wr_addr_q.size() > 0)
         check("max_last_addr", 64'(wr_addr_q[wr_addr_q.size()-1]), 64'hFF);
      check("max_count", 64'(word_count), 64'd256);
      check("max_done", 64'(load_done), 64'd1);

`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
      // Wrong checksum byte
      do_reset();
      send_image(0);
      send_byte(8'hC3, 0);
      idle();
      wait_done();
      check("csum_bad_err", 64'(load_err), 64'd1);
      check("csum_bad_done", 64'(load_done), 64'd0);
      check("csum_bad_cpu_rst", 64'(cpu_rst), 64'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
